// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: captures the LED sequence shown in each
// display phase and replays it as timed button presses until the game ends.
module jogador_automatico #(
    parameter int DEPTH        = 16,
    parameter int PRESS_CYCLES = 3,
    parameter int GAP_CYCLES   = 3,
    parameter int IDLE_CYCLES  = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       errar,
    input  logic [3:0] leds,
    input  logic       ganhou,
    input  logic       perdeu,
    input  logic       timeout,
    output logic       jogar,
    output logic [3:0] botoes,
    output logic       concluido,
    output logic       venceu,
    output logic       falhou,
    output logic       erro_captura,
    output logic [3:0] db_estado
);

    localparam int CW   = $clog2(DEPTH + 1);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = $clog2(IDLE_CYCLES + 1);

    typedef enum logic [3:0] {
        OCIOSO     = 4'd0,
        INICIA     = 4'd1,
        ESPERA_LED = 4'd2,
        GRAVA      = 4'd3,
        PRESSIONA  = 4'd4,
        SOLTA      = 4'd5,
        FIM        = 4'd6
    } estado_t;

    estado_t        estado_r;
    logic [3:0]     mem_r [0:(2**AW)-1];
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  idx_r;
    logic [TW-1:0]  tempo_r;
    logic [IW-1:0]  ocioso_r;
    logic [3:0]     ultimo_r;
    logic           errar_r;

    logic           status_s;
    logic           ativo_s;
    logic [CW-1:0]  prox_idx_s;
    logic           prox_err_s;
    logic [3:0]     mem_val_s;
    logic [3:0]     prox_botao_s;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [3:0] rot_esq(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    assign db_estado = estado_r;

    // Value to drive on the next press, including the deliberate wrong last press.
    always_comb begin
        status_s     = ganhou | perdeu | timeout;
        ativo_s      = 1'b0;
        prox_idx_s   = '0;
        prox_err_s   = 1'b0;
        mem_val_s    = 4'd0;
        prox_botao_s = 4'd0;
        if ((estado_r == ESPERA_LED) || (estado_r == GRAVA) ||
            (estado_r == PRESSIONA) || (estado_r == SOLTA)) begin
            ativo_s = 1'b1;
        end else begin
            ativo_s = 1'b0;
        end
        if (estado_r == SOLTA) begin
            prox_idx_s = idx_r + CW'(1);
            prox_err_s = errar_r;
        end else begin
            prox_idx_s = '0;
            prox_err_s = errar;
        end
        mem_val_s = mem_r[prox_idx_s[AW-1:0]];
        if (prox_err_s && (prox_idx_s == (cnt_r - CW'(1)))) begin
            prox_botao_s = rot_esq(mem_val_s);
        end else begin
            prox_botao_s = mem_val_s;
        end
    end

    // Player state machine with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_r     <= OCIOSO;
            cnt_r        <= '0;
            idx_r        <= '0;
            tempo_r      <= '0;
            ocioso_r     <= '0;
            ultimo_r     <= 4'd0;
            errar_r      <= 1'b0;
            jogar        <= 1'b0;
            botoes       <= 4'd0;
            concluido    <= 1'b0;
            venceu       <= 1'b0;
            falhou       <= 1'b0;
            erro_captura <= 1'b0;
            for (int i = 0; i < (2**AW); i++) begin
                mem_r[i] <= 4'd0;
            end
        end else if (ativo_s && status_s) begin
            // Game status wins over capture and replay in the same cycle.
            estado_r  <= FIM;
            botoes    <= 4'd0;
            concluido <= 1'b1;
            venceu    <= ganhou;
            falhou    <= perdeu | timeout;
        end else begin
            case (estado_r)
                OCIOSO: begin
                    if (iniciar) begin
                        estado_r <= INICIA;
                        jogar    <= 1'b1;
                    end else begin
                        estado_r <= OCIOSO;
                    end
                end
                INICIA: begin
                    jogar    <= 1'b0;
                    cnt_r    <= '0;
                    idx_r    <= '0;
                    tempo_r  <= '0;
                    ocioso_r <= '0;
                    estado_r <= ESPERA_LED;
                end
                ESPERA_LED: begin
                    if (leds != 4'd0) begin
                        ocioso_r <= '0;
                        if (!is_onehot(leds) || (cnt_r == CW'(DEPTH))) begin
                            erro_captura <= 1'b1;
                            concluido    <= 1'b1;
                            estado_r     <= FIM;
                        end else begin
                            mem_r[cnt_r[AW-1:0]] <= leds;
                            ultimo_r             <= leds;
                            cnt_r                <= cnt_r + CW'(1);
                            estado_r             <= GRAVA;
                        end
                    end else if (cnt_r != '0) begin
                        if (ocioso_r == IW'(IDLE_CYCLES)) begin
                            estado_r <= PRESSIONA;
                            idx_r    <= '0;
                            errar_r  <= errar;
                            botoes   <= prox_botao_s;
                            tempo_r  <= '0;
                        end else begin
                            ocioso_r <= ocioso_r + IW'(1);
                        end
                    end else begin
                        ocioso_r <= '0;
                    end
                end
                GRAVA: begin
                    if (leds == 4'd0) begin
                        ocioso_r <= '0;
                        estado_r <= ESPERA_LED;
                    end else if (leds != ultimo_r) begin
                        erro_captura <= 1'b1;
                        concluido    <= 1'b1;
                        estado_r     <= FIM;
                    end else begin
                        estado_r <= GRAVA;
                    end
                end
                PRESSIONA: begin
                    if (tempo_r == TW'(PRESS_CYCLES - 1)) begin
                        botoes   <= 4'd0;
                        tempo_r  <= '0;
                        estado_r <= SOLTA;
                    end else begin
                        tempo_r <= tempo_r + TW'(1);
                    end
                end
                SOLTA: begin
                    if (tempo_r == TW'(GAP_CYCLES - 1)) begin
                        tempo_r <= '0;
                        if (idx_r < (cnt_r - CW'(1))) begin
                            idx_r    <= prox_idx_s;
                            botoes   <= prox_botao_s;
                            estado_r <= PRESSIONA;
                        end else begin
                            cnt_r    <= '0;
                            idx_r    <= '0;
                            ocioso_r <= '0;
                            estado_r <= ESPERA_LED;
                        end
                    end else begin
                        tempo_r <= tempo_r + TW'(1);
                    end
                end
                FIM: begin
                    if (iniciar) begin
                        concluido    <= 1'b0;
                        venceu       <= 1'b0;
                        falhou       <= 1'b0;
                        erro_captura <= 1'b0;
                        estado_r     <= OCIOSO;
                    end else begin
                        estado_r <= FIM;
                    end
                end
                default: begin
                    estado_r  <= OCIOSO;
                    jogar     <= 1'b0;
                    botoes    <= 4'd0;
                    concluido <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jogador_automatico.sv
// Self-checking bench for jogador_automatico: random LED rounds are replayed and
// compared against a timing model built from the press/gap/idle rules.
module tb_jogador_automatico;

    localparam int DEPTH = 4;
    localparam int P     = 3;
    localparam int G     = 3;
    localparam int IDLE  = 8;

    logic       clock = 1'b0;
    logic       reset, iniciar, errar, ganhou, perdeu, timeout;
    logic [3:0] leds;
    logic       jogar, concluido, venceu, falhou, erro_captura;
    logic [3:0] botoes, db_estado;

    int n_assert = 0;
    int n_fail   = 0;
    logic [3:0] seq[$];

    jogador_automatico #(
        .DEPTH(DEPTH), .PRESS_CYCLES(P), .GAP_CYCLES(G), .IDLE_CYCLES(IDLE)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .errar(errar),
        .leds(leds), .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout),
        .jogar(jogar), .botoes(botoes), .concluido(concluido), .venceu(venceu),
        .falhou(falhou), .erro_captura(erro_captura), .db_estado(db_estado)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rand_onehot();
        return 4'b0001 << $urandom_range(0, 3);
    endfunction

    task automatic fill_random(input int n);
        seq.delete();
        for (int i = 0; i < n; i++) seq.push_back(rand_onehot());
    endtask

    // Stub game display: each entry held 1-4 cycles, 1-3 dark cycles in between.
    task automatic show();
        for (int i = 0; i < seq.size(); i++) begin
            leds = seq[i];
            repeat ($urandom_range(1, 4)) begin
                tick();
                chk("no_press_display", {4'd0, botoes}, 8'd0);
            end
            leds = 4'd0;
            if (i < seq.size() - 1) begin
                repeat ($urandom_range(1, 3)) begin
                    tick();
                    chk("no_press_gap", {4'd0, botoes}, 8'd0);
                end
            end
        end
    endtask

    // Expected button value t edges after the last LED went dark.
    function automatic logic [3:0] expected_press(input int t, input bit err);
        int u, i;
        logic [4:0] v;
        if (t < IDLE + 1) return 4'd0;
        u = t - (IDLE + 1);
        i = u / (P + G);
        if (i >= seq.size()) return 4'd0;
        if ((u % (P + G)) >= P) return 4'd0;
        v = {1'b0, seq[i]};
        if (err && (i == seq.size() - 1)) v = (v * 2) % 16 + v / 8;
        return v[3:0];
    endfunction

    task automatic replay_check(input bit err);
        int last;
        last = IDLE + 1 + seq.size() * (P + G);
        for (int t = 0; t <= last; t++) begin
            tick();
            chk($sformatf("replay_t%0d", t), {4'd0, botoes}, {4'd0, expected_press(t, err)});
        end
        chk("back_to_espera", {4'd0, db_estado}, 8'd2);
    endtask

    task automatic start_game();
        iniciar = 1'b1;
        tick();
        chk("start_jogar", {7'd0, jogar}, 8'd1);
        iniciar = 1'b0;
        tick();
        chk("start_espera", {4'd0, db_estado}, 8'd2);
        chk("start_jogar_low", {7'd0, jogar}, 8'd0);
    endtask

    task automatic leave_fim();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("leave_state", {4'd0, db_estado}, 8'd0);
        chk("leave_flags", {4'd0, concluido, venceu, falhou, erro_captura}, 8'd0);
    endtask

    initial begin
        int jogs;
        reset = 1'b1; iniciar = 1'b0; errar = 1'b0; leds = 4'd0;
        ganhou = 1'b0; perdeu = 1'b0; timeout = 1'b0;
        repeat (2) tick();
        chk("reset_state", {4'd0, db_estado}, 8'd0);
        chk("reset_botoes", {4'd0, botoes}, 8'd0);
        chk("reset_flags", {3'd0, jogar, concluido, venceu, falhou, erro_captura}, 8'd0);
        reset = 1'b0;

        // Start pulse with iniciar held for five cycles.
        jogs = 0;
        iniciar = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            jogs += int'(jogar);
            chk($sformatf("start_state_%0d", i), {4'd0, db_estado}, (i == 0) ? 8'd1 : 8'd2);
        end
        iniciar = 1'b0;
        chk("jogar_count", jogs[7:0], 8'd1);

        // Random rounds, then a win.
        for (int r = 0; r < 3; r++) begin
            fill_random($urandom_range(1, DEPTH));
            show();
            replay_check(1'b0);
        end
        ganhou = 1'b1;
        tick();
        ganhou = 1'b0;
        chk("win_flags", {5'd0, concluido, venceu, falhou}, 8'b110);
        chk("win_state", {4'd0, db_estado}, 8'd6);
        tick();
        chk("win_held", {5'd0, concluido, venceu, falhou}, 8'b110);
        leave_fim();

        // Error injection on the last press, then loss.
        start_game();
        errar = 1'b1;
        seq = '{4'b0100, 4'b1000};
        show();
        replay_check(1'b1);
        errar = 1'b0;
        perdeu = 1'b1;
        tick();
        perdeu = 1'b0;
        chk("loss_flags", {5'd0, concluido, venceu, falhou}, 8'b101);
        leave_fim();

        // Win and loss together latch both flags.
        start_game();
        ganhou = 1'b1; perdeu = 1'b1;
        tick();
        ganhou = 1'b0; perdeu = 1'b0;
        chk("both_flags", {5'd0, concluido, venceu, falhou}, 8'b111);
        leave_fim();

        // Reset in the middle of a press.
        start_game();
        fill_random(1);
        show();
        repeat (IDLE + 2) tick();
        chk("press_active", {4'd0, botoes}, {4'd0, seq[0]});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midpress_botoes", {4'd0, botoes}, 8'd0);
        chk("midpress_state", {4'd0, db_estado}, 8'd0);
        chk("midpress_flags", {3'd0, jogar, concluido, venceu, falhou, erro_captura}, 8'd0);

        // Timeout during a press releases the button.
        start_game();
        fill_random(2);
        show();
        repeat (IDLE + 3) tick();
        chk("press_active2", {4'd0, botoes}, {4'd0, seq[0]});
        timeout = 1'b1;
        tick();
        timeout = 1'b0;
        chk("to_press_botoes", {4'd0, botoes}, 8'd0);
        chk("to_press_flags", {5'd0, concluido, venceu, falhou}, 8'b101);
        leave_fim();

        // Invalid LED pattern.
        start_game();
        leds = 4'b0011;
        tick();
        leds = 4'd0;
        chk("invalid_err", {6'd0, erro_captura, concluido}, 8'b11);
        chk("invalid_state", {4'd0, db_estado}, 8'd6);
        leave_fim();

        // Capture overflow beyond DEPTH entries.
        start_game();
        fill_random(DEPTH);
        show();
        tick();
        chk("full_espera", {4'd0, db_estado}, 8'd2);
        leds = rand_onehot();
        tick();
        leds = 4'd0;
        chk("overflow_err", {7'd0, erro_captura}, 8'd1);
        chk("overflow_state", {4'd0, db_estado}, 8'd6);
        leave_fim();

        // Timeout while waiting for LEDs.
        start_game();
        timeout = 1'b1;
        tick();
        timeout = 1'b0;
        chk("to_wait_flags", {5'd0, concluido, venceu, falhou}, 8'b101);
        leave_fim();

        // Status beats a simultaneous LED capture.
        start_game();
        leds = 4'b0100;
        ganhou = 1'b1;
        tick();
        leds = 4'd0;
        ganhou = 1'b0;
        chk("prio_flags", {5'd0, venceu, falhou, erro_captura}, 8'b100);
        chk("prio_state", {4'd0, db_estado}, 8'd6);
        leave_fim();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
